// File: rtl/mdu_pkg.sv
// Shared types and opcode decode for the multiply/divide unit.
// Opcode values mirror the core's ALUOP_* encodings.
package mdu_pkg;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} mdu_state_t;

  localparam int MDU_DIV_ITERS = 32;

  localparam logic [7:0] ALUOP_MULT  = 8'h18;
  localparam logic [7:0] ALUOP_MULTU = 8'h19;
  localparam logic [7:0] ALUOP_DIV   = 8'h1A;
  localparam logic [7:0] ALUOP_DIVU  = 8'h1B;
  localparam logic [7:0] ALUOP_MADD  = 8'h1C;
  localparam logic [7:0] ALUOP_MADDU = 8'h1D;
  localparam logic [7:0] ALUOP_MSUB  = 8'h1E;
  localparam logic [7:0] ALUOP_MSUBU = 8'h1F;

  typedef struct packed {
    logic is_signed;
    logic is_div;
  } op_class_t;

  function automatic op_class_t classify(input logic [7:0] aluop);
    op_class_t c;
    c.is_signed = (aluop == ALUOP_MULT) || (aluop == ALUOP_MADD) ||
                  (aluop == ALUOP_MSUB) || (aluop == ALUOP_DIV);
    c.is_div    = (aluop == ALUOP_DIV) || (aluop == ALUOP_DIVU);
    return c;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage <-> multiply/divide unit bundle: op request in, stall/strobe/result out.
interface mdu_if;
  logic        start_i;
  logic [7:0]  aluop_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        stall_o;
  logic        done_o;
  logic [63:0] hilo_o;

  modport master (output start_i, aluop_i, a_i, b_i, flush_i,
                  input  stall_o, done_o, hilo_o);
  modport slave  (input  start_i, aluop_i, a_i, b_i, flush_i,
                  output stall_o, done_o, hilo_o);
endinterface

// File: rtl/div_radix2.sv
// Radix-2 restoring divider core on unsigned magnitudes, one quotient bit per step.
// quotient/remainder show the result of the step taken at the next edge.
module div_radix2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [32:0] shifted;
  logic [32:0] diff;

  // The dividend shifts out of quo_q while quotient bits shift in behind it.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, divisor};
  end

  assign quotient  = {quo_q[30:0], ~diff[32]};
  assign remainder = diff[32] ? shifted[31:0] : diff[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= 32'd0;
      rem_q <= 32'd0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= 32'd0;
    end else if (step) begin
      quo_q <= quotient;
      rem_q <= remainder;
    end
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle MULT/MADD/MSUB/DIV unit feeding HI/LO; stalls E while busy, one-cycle done strobe.
// Divider is built only when MDU_DIV_EN is defined; otherwise DIV/DIVU complete at once with 0.
module mdu
  import mdu_pkg::*;
(
  input logic   clk,
  input logic   rst,
  mdu_if.slave  bus
);

  mdu_state_t  state, state_nxt;
  op_class_t   cls;
  logic        accept;
  logic        stall;
  logic        done;
  logic [31:0] a_mag, b_mag;
  logic [31:0] abs_a, abs_b;
  logic        neg_q;
  logic [63:0] prod;
  logic [63:0] hilo;

  assign cls    = classify(bus.aluop_i);
  assign a_mag  = (cls.is_signed && bus.a_i[31]) ? -bus.a_i : bus.a_i;
  assign b_mag  = (cls.is_signed && bus.b_i[31]) ? -bus.b_i : bus.b_i;
  assign accept = (state == IDLE) && bus.start_i && !bus.flush_i;
  assign prod   = {32'd0, abs_a} * {32'd0, abs_b};

`ifdef MDU_DIV_EN
  logic [4:0]  cnt;
  logic        neg_r;
  logic        div_last;
  logic [31:0] quo, rem;

  assign div_last = (cnt == 5'(MDU_DIV_ITERS - 1));

  div_radix2 u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (accept && cls.is_div),
    .step      (state == DIV),
    .dividend  (a_mag),
    .divisor   (abs_b),
    .quotient  (quo),
    .remainder (rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= 5'd0;
      neg_r <= 1'b0;
    end else if (accept) begin
      cnt   <= 5'd0;
      neg_r <= cls.is_signed & bus.a_i[31];
    end else if (state == DIV) begin
      cnt   <= cnt + 5'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall = 1'b1;
          if (!cls.is_div) begin
            state_nxt = MUL;
          end else begin
`ifdef MDU_DIV_EN
            state_nxt = (bus.b_i == 32'd0) ? DONE : DIV;
`else
            state_nxt = DONE;
`endif
          end
        end
      end
      MUL: begin
        stall     = 1'b1;
        state_nxt = DONE;
      end
      DIV: begin
        stall = 1'b1;
`ifdef MDU_DIV_EN
        if (div_last) state_nxt = DONE;
`else
        state_nxt = IDLE;
`endif
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A flush kills whatever is in flight, including this cycle's strobe.
    if (bus.flush_i) begin
      state_nxt = IDLE;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abs_a <= 32'd0;
      abs_b <= 32'd0;
      neg_q <= 1'b0;
      hilo  <= 64'd0;
    end else if (accept) begin
      abs_a <= a_mag;
      abs_b <= b_mag;
      neg_q <= cls.is_signed & (bus.a_i[31] ^ bus.b_i[31]);
`ifdef MDU_DIV_EN
      if (cls.is_div && (bus.b_i == 32'd0)) hilo <= {bus.a_i, 32'hFFFF_FFFF};
`else
      if (cls.is_div) hilo <= 64'd0;
`endif
    end else if ((state == MUL) && !bus.flush_i) begin
      hilo <= neg_q ? -prod : prod;
    end
`ifdef MDU_DIV_EN
    else if ((state == DIV) && div_last && !bus.flush_i) begin
      hilo <= {(neg_r ? -rem : rem), (neg_q ? -quo : quo)};
    end
`endif
  end

  assign bus.stall_o = stall;
  assign bus.done_o  = done;
  assign bus.hilo_o  = hilo;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: multiply/divide results, strobe timing, flush and reset behaviour.
module tb_mdu;
  import mdu_pkg::*;

`ifdef MDU_DIV_EN
  localparam int          DIV_CYC  = 33;
  localparam logic [63:0] EXP_DIVN = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
  localparam logic [63:0] EXP_DMIN = {32'h0, 32'h8000_0000};
  localparam logic [63:0] EXP_DZ   = {32'h7, 32'hFFFF_FFFF};
  localparam logic [63:0] EXP_D100 = {32'd2, 32'd14};
  localparam logic [7:0]  LONG_OP  = ALUOP_DIVU;
  localparam int          FL_CYC   = 10;
  localparam int          RST_CYC  = 15;
`else
  localparam int          DIV_CYC  = 1;
  localparam logic [63:0] EXP_DIVN = 64'd0;
  localparam logic [63:0] EXP_DMIN = 64'd0;
  localparam logic [63:0] EXP_DZ   = 64'd0;
  localparam logic [63:0] EXP_D100 = 64'd0;
  localparam logic [7:0]  LONG_OP  = ALUOP_MULT;
  localparam int          FL_CYC   = 1;
  localparam int          RST_CYC  = 1;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mdu_if bus ();

  mdu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op at the next falling edge (cycle 0) and follow it to its strobe.
  task automatic run(input string tag, input logic [7:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int exp_cyc, input logic [63:0] exp_hilo);
    int   cyc;
    logic seen;
    logic stall_ok;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.aluop_i = op;
    bus.a_i     = a;
    bus.b_i     = b;
    cyc         = 0;
    seen        = 1'b0;
    stall_ok    = 1'b1;
    #1;
    while (!seen && cyc < 80) begin
      if (bus.done_o === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (bus.stall_o !== 1'b1) stall_ok = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b0;
        cyc++;
        #1;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_hilo"}, bus.hilo_o, exp_hilo);
    check({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
    check({tag, "_stall_at_done"}, 64'(bus.stall_o), 64'd0);
    @(negedge clk);
    #1;
    check({tag, "_done_one_cycle"}, 64'(bus.done_o), 64'd0);
  endtask

  initial begin
    logic done_any;
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.aluop_i = 8'h00;
    bus.a_i     = 32'd0;
    bus.b_i     = 32'd0;
    bus.flush_i = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_hilo", bus.hilo_o, 64'd0);
    check("rst_done", 64'(bus.done_o), 64'd0);
    check("rst_stall", 64'(bus.stall_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run("mult_neg", ALUOP_MULT, 32'hFFFF_FFFD, 32'd5, 2, 64'hFFFF_FFFF_FFFF_FFF1);
    run("multu_max", ALUOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 64'hFFFF_FFFE_0000_0001);
    run("maddu_max", ALUOP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 64'hFFFF_FFFE_0000_0001);
    run("msub_negneg", ALUOP_MSUB, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 2, 64'h8);
    run("madd_mixed", ALUOP_MADD, 32'd7, 32'hFFFF_FFFF, 2, 64'hFFFF_FFFF_FFFF_FFF9);
    run("div_neg", ALUOP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_CYC, EXP_DIVN);
    run("div_minint", ALUOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_CYC, EXP_DMIN);
    run("divu_zero", ALUOP_DIVU, 32'd7, 32'd0, 1, EXP_DZ);

    // Flush arriving in the DONE cycle suppresses the strobe.
    @(negedge clk);
    bus.start_i = 1'b1; bus.aluop_i = ALUOP_MULTU; bus.a_i = 32'd6; bus.b_i = 32'd7;
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    bus.flush_i = 1'b1;
    #1;
    check("flush_done_cycle_strobe", 64'(bus.done_o), 64'd0);
    check("flush_done_cycle_hilo", bus.hilo_o, 64'd42);
    @(negedge clk);
    bus.flush_i = 1'b0;
    #1;
    check("flush_done_next_done", 64'(bus.done_o), 64'd0);

    // Flush overrides a start in IDLE.
    @(negedge clk);
    bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.aluop_i = ALUOP_MULTU; bus.a_i = 32'd2; bus.b_i = 32'd2;
    #1;
    check("flush_vs_start_stall", 64'(bus.stall_o), 64'd0);
    @(negedge clk);
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    #1;
    check("flush_vs_start_idle", 64'(bus.stall_o), 64'd0);
    @(negedge clk);
    #1;
    check("flush_vs_start_nodone", 64'(bus.done_o), 64'd0);

    // Flush mid-operation: no strobe, result register untouched.
    run("multu_pre_flush", ALUOP_MULTU, 32'd3, 32'd3, 2, 64'd9);
    @(negedge clk);
    bus.start_i = 1'b1; bus.aluop_i = LONG_OP; bus.a_i = 32'd100; bus.b_i = 32'd7;
    for (int i = 0; i < FL_CYC; i++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
    end
    bus.flush_i = 1'b1;
    #1;
    check("flush_mid_strobe", 64'(bus.done_o), 64'd0);
    @(negedge clk);
    bus.flush_i = 1'b0;
    #1;
    check("flush_mid_idle", 64'(bus.stall_o), 64'd0);
    check("flush_mid_hilo", bus.hilo_o, 64'd9);
    done_any = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (bus.done_o === 1'b1) done_any = 1'b1;
    end
    check("flush_mid_no_late_done", 64'(done_any), 64'd0);
    run("mult_after_flush", ALUOP_MULT, 32'hFFFF_FFFD, 32'd5, 2, 64'hFFFF_FFFF_FFFF_FFF1);

    // Reset mid-operation abandons it and clears outputs immediately.
    @(negedge clk);
    bus.start_i = 1'b1; bus.aluop_i = LONG_OP; bus.a_i = 32'd1000; bus.b_i = 32'd3;
    for (int i = 0; i < RST_CYC; i++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("rst_mid_hilo", bus.hilo_o, 64'd0);
    check("rst_mid_done", 64'(bus.done_o), 64'd0);
    check("rst_mid_stall", 64'(bus.stall_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run("divu_after_rst", ALUOP_DIVU, 32'd100, 32'd7, DIV_CYC, EXP_D100);
    run("multu_after_rst", ALUOP_MULTU, 32'd100, 32'd7, 2, 64'd700);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit sitting in the execute stage beside the ALU. It is the producer side of the HI/LO register. It accepts MULT/MULTU/MADD/MADDU/MSUB/MSUBU/DIV/DIVU operations and stalls the pipeline while it works. It then delivers a 64-bit {hi, lo} result with a one-cycle write strobe that the HI/LO register consumes; MADD/MSUB accumulation stays in the HI/LO register, so this block only supplies the product.

## Interface
- No parameters; operation codes `ALUOP_*` come from `defines.vh`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `start_i` input 1: E-stage instruction is a mul/div op, operands valid.
- `aluop_i` input 8: operation code.
- `a_i` input 32: rs value (dividend / multiplicand).
- `b_i` input 32: rt value (divisor / multiplier).
- `flush_i` input 1: cancel the in-flight op (exception / pipeline flush).
- `stall_o` output 1: hold the E stage.
- `done_o` output 1: one-cycle HI/LO write strobe.
- `hilo_o` output 64: result; {hi, lo}.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - When `start_i` is high and `flush_i` is low, latch `aluop_i`, `a_i` and `b_i`.
  - Signed ops are MULT, MADD, MSUB and DIV; they latch absolute values plus the result signs.
  - Multiply ops go to MUL.
  - Divide ops with `b_i` nonzero go to DIV with the iteration counter at 0.
  - Divide ops with `b_i`==0 go to DONE with `hilo_o`={a_i, 32'hFFFFFFFF}.
- MUL: 32x32 to 64 product (signed or unsigned) is registered into `hilo_o`, then DONE.
- DIV:
  - Radix-2 restoring division, one quotient bit per cycle; counter runs 0..31.
  - At count 31, sign-correct and register `hilo_o`={remainder, quotient}, then DONE.
  - Quotient is negated when the operand signs differ. Remainder takes the sign of the dividend.
  - Arithmetic is 32-bit wrap: 0x80000000 / -1 gives quotient 0x80000000, remainder 0.
- DONE: `done_o`=1 and `stall_o`=0 for exactly one cycle, then IDLE. `start_i` is ignored in DONE (the same instruction is still in E).
- `stall_o` = (IDLE & `start_i` & ~`flush_i`) | MUL | DIV. It is combinational in the accept cycle.
- `flush_i`:
  - From any state it forces IDLE on the next edge and cancels `done_o` in the current cycle.
  - It overrides `start_i`.
  - `hilo_o` keeps its last value.
- Reset: state IDLE, counter 0, `hilo_o`=0, `done_o`=0, `stall_o` driven only by the IDLE term. Reset mid-divide abandons the operation.

## Timing
- Accept cycle = cycle 0.
- MUL: `done_o` at cycle 2, so the stall covers cycles 0-1.
- DIV: `done_o` at cycle 33, so the stall covers cycles 0-32.
- Divide by zero: `done_o` at cycle 1.
- `hilo_o` is valid when `done_o` is high and holds until the next result.
- Back-to-back ops: a new `start_i` is accepted at the first IDLE cycle after DONE.

## Configuration
- `MDU_DIV_EN` defined: the divider is built as described above.
- `MDU_DIV_EN` undefined:
  - No divider logic is built and the DIV state is unreachable.
  - DIV/DIVU go IDLE -> DONE, with `done_o` at cycle 1 and `hilo_o`=64'd0.
  - Multiplies are unchanged.

## Structure
- Shared package `mdu_pkg`:
  - `mdu_state_t` enum {IDLE, MUL, DIV, DONE}.
  - `MDU_DIV_ITERS`=32.
  - A function classifying `aluop` as signed/unsigned and mul/div.
- Sub-module `div_radix2`, the iterative divider core:
  - Inputs: load, absolute operands.
  - Per-cycle step.
  - Outputs: quotient, remainder.
  - Instantiated only under `MDU_DIV_EN`.

## Test plan
- MULT a=-3, b=5 -> `done_o` at cycle 2, `hilo_o`=64'hFFFFFFFF_FFFFFFF1; `stall_o` high cycles 0-1.
- MULTU a=b=32'hFFFFFFFF -> `hilo_o`=64'hFFFFFFFE_00000001 at cycle 2; MADDU with the same operands gives the identical product.
- DIV a=-7, b=2 -> `done_o` at cycle 33, `hilo_o`={32'hFFFFFFFF, 32'hFFFFFFFD}. DIV a=32'h80000000, b=-1 -> {0, 32'h80000000}.
- DIVU a=7, b=0 -> `done_o` at cycle 1, `hilo_o`={32'h7, 32'hFFFFFFFF}; with `MDU_DIV_EN` undefined -> `done_o` at cycle 1, `hilo_o`=0.
- `flush_i` at cycle 10 of a DIVU -> IDLE next cycle, no `done_o`, `hilo_o` unchanged. A MULT started the following cycle completes 2 cycles later.
- `rst` pulsed mid-divide (cycle 15) -> outputs immediately at reset values, no `done_o`. After release, DIVU 100/7 -> {2, 14} at cycle 33.
